game_state_ctrl: RTL

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/game_state_ctrl.sv
// Game flow FSM for a flappy-style game: start, play, die, hold-off, restart.
// Tracks collisions, the BCD score and the best score since reset.
module game_state_ctrl #(
  parameter int BIRD_X    = 160,
  parameter int BIRD_SIZE = 16,
  parameter int PIPE_W    = 52,
  parameter int GAP_H     = 120,
  parameter int GROUND_Y  = 464,
  parameter int OVER_HOLD = 64
) (
  input  logic        gameClk,
  input  logic        reset,
  input  logic        button,
  input  logic [10:0] bird_y,
  input  logic [10:0] pipe1_x,
  input  logic [10:0] pipe1_y,
  input  logic [10:0] pipe2_x,
  input  logic [10:0] pipe2_y,
  input  logic        passColumn,
  output logic        finished,
  output logic        playing,
  output logic        collide,
  output logic [15:0] score_bcd,
  output logic [15:0] best_bcd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAYING,
    S_DYING,
    S_OVER
  } state_t;

  localparam logic [11:0] BX0  = 12'(BIRD_X);
  localparam logic [11:0] BX1  = 12'(BIRD_X + BIRD_SIZE);
  localparam logic [11:0] BS   = 12'(BIRD_SIZE);
  localparam logic [11:0] PW   = 12'(PIPE_W);
  localparam logic [11:0] GH   = 12'(GAP_H);
  localparam logic [11:0] GND  = 12'(GROUND_Y);
  localparam logic [6:0]  HOLD = 7'(OVER_HOLD);
  localparam logic [15:0] SMAX = 16'h9999;

  state_t      state;
  state_t      state_nx;
  logic [6:0]  hold_cnt;
  logic        hold_done;
  logic [11:0] by;
  logic        hit_a;
  logic        hit_b;
  logic        hit_gnd;
  logic        hit_top;
  logic        score_en;

  // Hit when the x-spans overlap and the bird is not fully inside the gap.
  function automatic logic col_hit(
    input logic [11:0] px,
    input logic [11:0] py,
    input logic [11:0] y
  );
    logic x_ov;
    logic y_in;
    x_ov = (BX0 < px + PW) && (px < BX1);
    y_in = (y >= py) && (y + BS <= py + GH);
    return x_ov && !y_in;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign by      = {1'b0, bird_y};
  assign hit_a   = col_hit({1'b0, pipe1_x}, {1'b0, pipe1_y}, by);
  assign hit_b   = col_hit({1'b0, pipe2_x}, {1'b0, pipe2_y}, by);
  assign hit_gnd = (by + BS >= GND);
  assign hit_top = (by == 12'd0);

  assign hold_done = (hold_cnt >= HOLD);
  assign score_en  = (state == S_PLAYING) && passColumn
                   && !collide && (score_bcd != SMAX);

  always_ff @(posedge gameClk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (button) state_nx = S_PLAYING;
      S_PLAYING: if (collide) state_nx = S_DYING;
      S_DYING:   state_nx = S_OVER;
      S_OVER:    if (button && hold_done) state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    finished = 1'b0;
    playing  = 1'b0;
    unique case (state)
      S_IDLE:    ;
      S_PLAYING: playing = 1'b1;
      S_DYING:   finished = 1'b1;
      S_OVER:    finished = 1'b1;
    endcase
  end

  always_ff @(posedge gameClk or negedge reset) begin
    if (!reset) begin
      collide   <= 1'b0;
      score_bcd <= 16'h0000;
      best_bcd  <= 16'h0000;
      hold_cnt  <= 7'd0;
    end else begin
      collide <= hit_a | hit_b | hit_gnd | hit_top;
      if (state == S_IDLE && button) begin
        score_bcd <= 16'h0000;
      end else if (score_en) begin
        score_bcd <= bcd_inc(score_bcd);
      end
      // Packed BCD orders the same as binary, so a plain compare works.
      if (state == S_DYING && score_bcd > best_bcd) begin
        best_bcd <= score_bcd;
      end
      if (state != S_OVER) begin
        hold_cnt <= 7'd0;
      end else if (!hold_done) begin
        hold_cnt <= hold_cnt + 7'd1;
      end
    end
  end

endmodule
